// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for the pipelined adder slice.
//   - default width/depth of the adder
//   - per-stage control payload (valid bit plus carry between chunks)
//   - full-adder cell used by every ripple chunk
//   - chunk-width helper and a configuration check used at elaboration
package adder_pkg;

    localparam int unsigned DefaultWidth  = 32;
    localparam int unsigned DefaultStages = 4;

    // Control part of the stage payload. The data part (partial sum and the
    // not-yet-added operand chunks) depends on the module parameters and
    // lives next to it in the top level.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctrl_t;

    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return width / stages;
    endfunction

    function automatic bit config_ok(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// rca_chunk: combinational W-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a, b   W-bit operands
//   cin    carry into bit 0
//   sum    W-bit sum
//   cout   carry out of bit W-1
//   c_msb  carry into bit W-1 (used for signed overflow detection)
module rca_chunk
    import adder_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    always_comb begin : p_ripple
        logic       carry;
        logic [1:0] fa;
        sum   = '0;
        fa    = '0;
        carry = cin;
        c_msb = cin;
        for (int i = 0; i < int'(W); i++) begin
            c_msb  = carry;  // after the last iteration: carry into bit W-1
            fa     = full_add(a[i], b[i], carry);
            sum[i] = fa[0];
            carry  = fa[1];
        end
        cout = carry;
    end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into STAGES ripple chunks of
// CW = WIDTH/STAGES bits, one register stage per chunk, valid/ready on both sides.
// Ports:
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   i_valid, o_ready    input handshake; o_ready = !o_valid || i_ready
//   i_a, i_b, i_carry   operands and carry-in
//   o_valid, i_ready    output handshake
//   o_sum, o_carry      A+B+cin modulo 2^WIDTH and carry out of bit WIDTH-1
//   o_ovf               signed overflow, present only when PIPELINED_ADDER_OVF_EN is defined
// The whole pipe advances or freezes as one; bubbles travel as valid=0.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DefaultWidth,
    parameter int unsigned STAGES = DefaultStages
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
`ifdef PIPELINED_ADDER_OVF_EN
    output logic             o_ovf,
`endif
    output logic             o_carry
);

    localparam int unsigned CW = chunk_width(WIDTH, STAGES);

    if (!config_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    logic advance;
    assign advance = !o_valid || i_ready;
    assign o_ready = advance;

    // Stage k inputs. Operands are kept right-aligned (next chunk in the LSBs);
    // finished sum chunks enter at the top and shift down, so after the last
    // stage chunk 0 sits in the LSBs.
    logic [WIDTH-1:0] a_in    [STAGES];
    logic [WIDTH-1:0] b_in    [STAGES];
    logic [WIDTH-1:0] s_in    [STAGES];
    stage_ctrl_t      ctrl_in [STAGES];

    assign a_in[0]    = i_a;
    assign b_in[0]    = i_b;
    assign s_in[0]    = '0;
    assign ctrl_in[0] = stage_ctrl_t'{valid: i_valid, carry: i_carry};

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        logic [CW-1:0]    chunk_sum;
        logic             chunk_cout;
        logic             chunk_cmsb;
        logic [WIDTH-1:0] a_nxt;
        logic [WIDTH-1:0] b_nxt;
        logic [WIDTH-1:0] s_nxt;

        rca_chunk #(
            .W (CW)
        ) u_rca (
            .a     (a_in[k][CW-1:0]),
            .b     (b_in[k][CW-1:0]),
            .cin   (ctrl_in[k].carry),
            .sum   (chunk_sum),
            .cout  (chunk_cout),
            .c_msb (chunk_cmsb)
        );

        assign a_nxt = a_in[k] >> CW;
        assign b_nxt = b_in[k] >> CW;
        assign s_nxt = (s_in[k] >> CW) | (WIDTH'(chunk_sum) << (WIDTH - CW));

        if (k < int'(STAGES) - 1) begin : g_mid
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] s_q;
            stage_ctrl_t      ctrl_q;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    a_q    <= '0;
                    b_q    <= '0;
                    s_q    <= '0;
                    ctrl_q <= '0;
                end else if (advance) begin
                    a_q    <= a_nxt;
                    b_q    <= b_nxt;
                    s_q    <= s_nxt;
                    ctrl_q <= stage_ctrl_t'{valid: ctrl_in[k].valid, carry: chunk_cout};
                end
            end

            assign a_in[k+1]    = a_q;
            assign b_in[k+1]    = b_q;
            assign s_in[k+1]    = s_q;
            assign ctrl_in[k+1] = ctrl_q;

            // Only the last chunk's MSB carry feeds overflow.
            logic unused_cmsb;
            assign unused_cmsb = chunk_cmsb;
        end else begin : g_last
            logic [WIDTH-1:0] sum_q;
            logic             carry_q;
            logic             valid_q;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    sum_q   <= '0;
                    carry_q <= 1'b0;
                    valid_q <= 1'b0;
                end else if (advance) begin
                    sum_q   <= s_nxt;
                    carry_q <= chunk_cout;
                    valid_q <= ctrl_in[k].valid;
                end
            end

            assign o_sum   = sum_q;
            assign o_carry = carry_q;
            assign o_valid = valid_q;

`ifdef PIPELINED_ADDER_OVF_EN
            logic ovf_q;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= chunk_cout ^ chunk_cmsb;
                end
            end
            assign o_ovf = ovf_q;
`else
            logic unused_cmsb;
            assign unused_cmsb = chunk_cmsb;
`endif

            // Operands are fully consumed here; the shifted remainders are all zero.
            logic unused_rem;
            assign unused_rem = ^{a_nxt, b_nxt};
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=32). The driver pushes the
// expected response on every input transfer; an independent monitor pops and
// compares on every output transfer, and also checks o_ready and stall hold.
module tb_pipelined_adder;

    localparam int unsigned WIDTH = 32;
    parameter int unsigned STAGES = 4;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_carry;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;
`ifdef PIPELINED_ADDER_OVF_EN
    logic             o_ovf;
`endif

    always #5 i_clk = ~i_clk;

    pipelined_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_carry (i_carry),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
`ifdef PIPELINED_ADDER_OVF_EN
        .o_ovf   (o_ovf),
`endif
        .o_carry (o_carry)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int unsigned edge_no;
        logic        chk;
    } exp_t;

    vec_t vecs  [$];
    exp_t exp_q [$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   edge_cnt = 0;

    always @(posedge i_clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void add_vec(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                    input logic [31:0] sum, input logic cout, input logic ovf);
        vecs.push_back(vec_t'{a: a, b: b, cin: cin, sum: sum, cout: cout, ovf: ovf});
    endfunction

    // Reference model for the random phase.
    function automatic void add_model_vec(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin);
        logic [32:0] full;
        full = {1'b0, a} + {1'b0, b} + 33'(cin);
        add_vec(a, b, cin, full[31:0], full[32], (a[31] == b[31]) && (full[31] != a[31]));
    endfunction

    // mode 0: i_ready always 1 (latency checked); 1: i_ready low on cycles 6..8;
    // 2: i_ready random at 70%.
    task automatic drive_queue(input int mode, input int unsigned valid_pct);
        int   cyc;
        int   limit;
        vec_t v;
        exp_t e;
        cyc   = 0;
        limit = 40 * vecs.size() + 200;
        while (vecs.size() > 0) begin
            @(negedge i_clk);
            case (mode)
                1:       i_ready = !(cyc >= 6 && cyc <= 8);
                2:       i_ready = ($urandom_range(99) < 70);
                default: i_ready = 1'b1;
            endcase
            v       = vecs[0];
            i_valid = ($urandom_range(99) < valid_pct);
            i_a     = v.a;
            i_b     = v.b;
            i_carry = v.cin;
            #2;
            if (i_valid && o_ready) begin
                e.sum     = v.sum;
                e.cout    = v.cout;
                e.ovf     = v.ovf;
                e.edge_no = unsigned'(edge_cnt + 1);
                e.chk     = (mode == 0);
                exp_q.push_back(e);
                void'(vecs.pop_front());
            end
            cyc++;
            if (cyc > limit) begin
                n_tests++;
                n_fail++;
                $display("FAIL driver_timeout: %0d vectors left, expected 0", vecs.size());
                vecs.delete();
            end
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < int'(8 * STAGES + 100)) begin
            @(negedge i_clk);
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: samples 1 time unit after the falling edge.
    logic        held;
    logic [31:0] held_sum;
    logic        held_c;
    logic        held_ovf;
    exp_t        got;

    always begin
        @(negedge i_clk);
        #1;
        if (i_rst) begin
            held = 1'b0;
        end else begin
            check("o_ready", 32'(o_ready), 32'(!o_valid || i_ready));
            if (held) begin
                check("hold_valid", 32'(o_valid), 32'd1);
                check("hold_sum", o_sum, held_sum);
                check("hold_carry", 32'(o_carry), 32'(held_c));
`ifdef PIPELINED_ADDER_OVF_EN
                check("hold_ovf", 32'(o_ovf), 32'(held_ovf));
`endif
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_result: got sum %h, expected no output", o_sum);
                end else begin
                    got = exp_q.pop_front();
                    check("sum", o_sum, got.sum);
                    check("carry", 32'(o_carry), 32'(got.cout));
`ifdef PIPELINED_ADDER_OVF_EN
                    check("ovf", 32'(o_ovf), 32'(got.ovf));
`endif
                    if (got.chk) begin
                        check("latency", 32'(edge_cnt + 1) - got.edge_no, 32'(STAGES));
                    end
                end
            end
            held     = o_valid && !i_ready;
            held_sum = o_sum;
            held_c   = o_carry;
`ifdef PIPELINED_ADDER_OVF_EN
            held_ovf = o_ovf;
`else
            held_ovf = 1'b0;
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_a     = '0;
        i_b     = '0;
        i_carry = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_sum", o_sum, 32'd0);
        check("rst_carry", 32'(o_carry), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
`ifdef PIPELINED_ADDER_OVF_EN
        check("rst_ovf", 32'(o_ovf), 32'd0);
`endif
        @(negedge i_clk);
        i_rst = 1'b0;

        // Directed vectors, hand-computed: each alone, then all back-to-back.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 9; i++) begin
                case (i)
                    0: add_vec(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
                    1: add_vec(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
                    2: add_vec(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
                    3: add_vec(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
                    4: add_vec(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
                    5: add_vec(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0);
                    6: add_vec(32'h0000_0005, 32'hFFFF_FFFC, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
                    7: add_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
                    default: add_vec(32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 32'h0001_FFFF, 1'b0, 1'b0);
                endcase
                if (pass == 0) begin
                    drive_queue(0, 100);
                    drain();
                end
            end
            if (pass == 1) begin
                drive_queue(0, 100);
                drain();
            end
        end

        // Stream of 8 with a 3-cycle consumer stall: A=i, B=0x10*i -> 0x11*i.
        for (int i = 1; i <= 8; i++) begin
            add_vec(32'(i), 32'(16 * i), 1'b0, 32'(17 * i), 1'b0, 1'b0);
        end
        drive_queue(1, 100);
        drain();

        // Random operands and handshakes against the reference model.
        for (int i = 0; i < 300; i++) begin
            add_model_vec($urandom(), $urandom(), 1'($urandom_range(1)));
        end
        drive_queue(2, 50);
        drain();

        // Reset with three operations in flight, first result stalled at the output.
        add_vec(32'h1111_1111, 32'h2222_2222, 1'b0, 32'h3333_3333, 1'b0, 1'b0);
        add_vec(32'h4444_4444, 32'h1111_1111, 1'b1, 32'h5555_5556, 1'b0, 1'b0);
        add_vec(32'hF000_0000, 32'h1000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        drive_queue(0, 100);
        i_ready = 1'b0;
        n = 0;
        while (!o_valid && n < int'(4 * STAGES + 10)) begin
            @(negedge i_clk);
            n++;
        end
        check("stalled_before_reset", 32'(o_valid), 32'd1);
        #3;
        i_rst = 1'b1;
        #1;
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_sum", o_sum, 32'd0);
        check("midrst_carry", 32'(o_carry), 32'd0);
`ifdef PIPELINED_ADDER_OVF_EN
        check("midrst_ovf", 32'(o_ovf), 32'd0);
`endif
        exp_q.delete();
        i_ready = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(o_ready), 32'd1);
        add_vec(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
        drive_queue(0, 100);
        drain();
        repeat (STAGES + 4) @(negedge i_clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
